// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the gray2bin_stream decoder and its verification models.
// Functions work on GRAY_W_MAX-bit words; narrower words are zero-extended, which
// leaves both conversions and the popcount unchanged.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 32;

  // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    logic                  acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_W_MAX - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  // Binary -> Gray: each bit XORed with its upper neighbour.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Number of set bits; used as the Hamming distance between consecutive codes.
  function automatic int popcount(input logic [GRAY_W_MAX-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < GRAY_W_MAX; i++) begin
      n += v[i] ? 1 : 0;
    end
    return n;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Pure combinational Gray-to-binary decoder (XOR prefix from the MSB down).
module gray2bin_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Running XOR from the MSB; a scalar accumulator keeps bin free of self-reads.
  always_comb begin
    logic acc;
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    bin = '0;
    acc = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/gray2bin_stream.sv
// Streaming Gray-to-binary decoder with a one-deep registered valid/ready output.
// Optional feature macro GRAY_STEP_CHECK_EN adds step_err, flagging any accepted word
// whose Hamming distance from the previously accepted word exceeds one.
module gray2bin_stream
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT  // 2 .. GRAY_W_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef GRAY_STEP_CHECK_EN
  output logic             step_err,
`endif
  output logic [WIDTH-1:0] out_bin
);

  logic [WIDTH-1:0] dec_bin;
  logic             accept;
  logic             consume;

  gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
    .gray (in_gray),
    .bin  (dec_bin)
  );

  // The output slot can take a word when it is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // Output register: load on accept, empty on consume, otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      out_valid <= 1'b0;
      out_bin   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_bin   <= dec_bin;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             first_flag;
  logic             big_step;

  // More than one bit changed since the previous accepted word.
  assign big_step = popcount(GRAY_W_MAX'(in_gray ^ prev_gray)) > 1;

  // Step checker: evaluated on accept only, so step_err holds with out_bin under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_err   <= 1'b0;
      prev_gray  <= '0;
      first_flag <= 1'b1;
    end else if (accept) begin
      step_err   <= !first_flag && big_step;
      prev_gray  <= in_gray;
      first_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_gray2bin_stream.sv
// Directed self-checking bench for gray2bin_stream (WIDTH=4). Inputs are driven and
// outputs sampled on the falling edge; the DUT updates on the rising edge.
// Step-error checks are compiled only when GRAY_STEP_CHECK_EN is defined.
module tb_gray2bin_stream;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_gray;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_bin;
`ifdef GRAY_STEP_CHECK_EN
  logic         step_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Gray codes of 0..15, written out by hand.
  logic [W-1:0] gray_tbl [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  gray2bin_stream #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gray   (in_gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef GRAY_STEP_CHECK_EN
    .step_err  (step_err),
`endif
    .out_bin   (out_bin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] g, input logic r);
    in_valid  = v;
    in_gray   = g;
    out_ready = r;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with a word offered: nothing may be accepted.
    rst = 1'b1;
    drive(1'b1, 4'b0110, 1'b1);
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bin",   32'(out_bin),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef GRAY_STEP_CHECK_EN
    check("rst_step_err",  32'(step_err),  32'd0);
`endif
    rst = 1'b0;
    drive(1'b0, 'x, 1'b1);  // X on in_gray tolerated while idle
    tick();
    check("rst_nothing_accepted", 32'(out_valid), 32'd0);

    // Single words.
    drive(1'b1, 4'b0110, 1'b1);
    tick();
    check("single_0110_valid", 32'(out_valid), 32'd1);
    check("single_0110_bin",   32'(out_bin),   32'b0100);
`ifdef GRAY_STEP_CHECK_EN
    check("single_0110_err",   32'(step_err),  32'd0);
`endif
    drive(1'b1, 4'b1000, 1'b1);
    tick();
    check("single_1000_bin",   32'(out_bin),   32'b1111);
`ifdef GRAY_STEP_CHECK_EN
    check("single_1000_err",   32'(step_err),  32'd1);  // 0110 -> 1000 flips 3 bits
`endif
    drive(1'b1, 4'b0000, 1'b1);
    tick();
    check("single_0000_bin",   32'(out_bin),   32'b0000);
    check("single_0000_valid", 32'(out_valid), 32'd1);
`ifdef GRAY_STEP_CHECK_EN
    check("single_0000_err",   32'(step_err),  32'd0);
`endif
    drive(1'b0, 4'b0000, 1'b1);
    tick();
    check("single_drained", 32'(out_valid), 32'd0);

    // Full back-to-back stream of all 16 codes.
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        check($sformatf("stream_valid_%0d", i - 1), 32'(out_valid), 32'd1);
        check($sformatf("stream_bin_%0d", i - 1),   32'(out_bin),   32'(i - 1));
        check($sformatf("stream_ready_%0d", i - 1), 32'(in_ready),  32'd1);
`ifdef GRAY_STEP_CHECK_EN
        check($sformatf("stream_err_%0d", i - 1),   32'(step_err),  32'd0);
`endif
      end
      if (i < 16) drive(1'b1, gray_tbl[i], 1'b1);
      else        drive(1'b0, 4'b0000, 1'b1);
      tick();
    end
    check("stream_drained", 32'(out_valid), 32'd0);

    // Backpressure: 0111 (bin 0101) held for 3 cycles while 1111 waits.
    drive(1'b1, 4'b0111, 1'b1);
    tick();
    check("bp_first_bin", 32'(out_bin), 32'b0101);
`ifdef GRAY_STEP_CHECK_EN
    check("bp_first_err", 32'(step_err), 32'd1);  // 1000 -> 0111 flips 4 bits
`endif
    drive(1'b1, 4'b1111, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("bp_hold_ready_%0d", c), 32'(in_ready),  32'd0);
      check($sformatf("bp_hold_valid_%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_bin_%0d", c),   32'(out_bin),   32'b0101);
`ifdef GRAY_STEP_CHECK_EN
      check($sformatf("bp_hold_err_%0d", c),   32'(step_err),  32'd1);
`endif
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd1);
    check("bp_release_bin",   32'(out_bin),   32'b1010);
`ifdef GRAY_STEP_CHECK_EN
    check("bp_release_err",   32'(step_err),  32'd0);
`endif
    drive(1'b0, 4'b0000, 1'b1);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Reset while a word is pending: it must be discarded.
    drive(1'b1, 4'b0101, 1'b1);
    tick();
    check("midrst_pending_bin", 32'(out_bin), 32'b0110);
    rst = 1'b1;
    drive(1'b1, 4'b0011, 1'b0);
    tick();
    check("midrst_valid",    32'(out_valid), 32'd0);
    check("midrst_bin",      32'(out_bin),   32'd0);
    check("midrst_in_ready", 32'(in_ready),  32'd1);
    rst = 1'b0;
    drive(1'b0, 4'b0000, 1'b1);
    tick();
    check("midrst_no_ghost", 32'(out_valid), 32'd0);

    // Step sequence 0000, 0011, 0010, 0010 straight after reset.
    drive(1'b1, 4'b0000, 1'b1);
    tick();
    check("step_0000_bin", 32'(out_bin), 32'b0000);
`ifdef GRAY_STEP_CHECK_EN
    check("step_0000_err", 32'(step_err), 32'd0);
`endif
    drive(1'b1, 4'b0011, 1'b1);
    tick();
    check("step_0011_bin", 32'(out_bin), 32'b0010);
`ifdef GRAY_STEP_CHECK_EN
    check("step_0011_err", 32'(step_err), 32'd1);
`endif
    drive(1'b1, 4'b0010, 1'b1);
    tick();
    check("step_0010_bin", 32'(out_bin), 32'b0011);
`ifdef GRAY_STEP_CHECK_EN
    check("step_0010_err", 32'(step_err), 32'd0);
`endif
    drive(1'b1, 4'b0010, 1'b1);
    tick();
    check("step_repeat_bin", 32'(out_bin), 32'b0011);
`ifdef GRAY_STEP_CHECK_EN
    check("step_repeat_err", 32'(step_err), 32'd0);
`endif
    drive(1'b0, 4'b0000, 1'b1);
    tick();
    check("step_drained", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
